uart_tx_mmio: RTL
=================

// Module: uart_tx_mmio
// PURPOSE
//   Memory-mapped UART transmitter that responds to the core's data-memory bus (same signalling as dcache).
//   The core stores bytes to TXDATA; the block buffers them and serialises each as 8N1 on tx_o.
//   Sits beside dcache behind the address decoder and gives the single-cycle core a visible output channel.
// PARAMETERS
//   BAUD_DIV    434  reset value of the divisor: clk cycles per bit (50 MHz / 115200)
//   FIFO_DEPTH  4    TX FIFO entries; must be a power of 2, >= 2
// PORTS
//   clk_i       in   1   single clock, rising edge
//   rst_ni      in   1   asynchronous, active-low reset
//   addr_i      in   6   word address (core drives ex_resultado[7:2])
//   dato_i      in   32  store data
//   memwrite_i  in   1   store strobe, sampled on rising clk_i
//   memread_i   in   1   load strobe, combinational read
//   dato_o      out  32  load data; 0 when memread_i=0
//   tx_o        out  1   serial line, idle high
//   busy_o      out  1   1 while a frame is active or the FIFO is non-empty
// BEHAVIOUR
//   Reset: tx_o=1, busy_o=0, FIFO empty, overflow=0, div_r=BAUD_DIV, FSM=IDLE, counters 0.
//     Reset is effective immediately, including mid-frame (tx_o forced high, FIFO flushed).
//   Register map (addr_i):
//     0 TXDATA   wr: push dato_i[7:0] if FIFO not full, else drop byte and set overflow. rd: 0.
//     1 STATUS   rd: {24'b0, count[3:0], overflow, empty, full, busy}. wr: dato_i[3]=1 clears overflow.
//     2 BAUDDIV  rd/wr: div_r[15:0]; upper bits read 0. A written 0 is stored as 1.
//     others     rd 0, wr ignored.
//   Reads are combinational (no state change). Writes act on the rising edge where memwrite_i=1.
//   FSM states:
//     IDLE:  if FIFO non-empty: pop, latch byte into shift_r, latch div_r into bdiv_r -> START.
//     START: tx_o=0 for bdiv_r cycles -> DATA.
//     DATA:  tx_o=shift_r[0], LSB first, bdiv_r cycles per bit; after bit 7 -> STOP.
//     STOP:  tx_o=1 for bdiv_r cycles. Then: FIFO non-empty -> pop, relatch, START (no idle gap);
//            otherwise -> IDLE.
//   Counters: baud_cnt counts 0..bdiv_r-1 and wraps at the bit boundary; bit_cnt counts 0..7.
//   Frame length is exactly 10*bdiv_r cycles.
//   A BAUDDIV write mid-frame does not change the current frame; it takes effect at the next pop.
//   Latency: a TXDATA write at edge E into an empty FIFO with FSM in IDLE -> pop at edge E+1,
//     tx_o low from E+1.
//   FIFO edge cases:
//     - Push and pop on the same edge: both occur; count is unchanged, including when full.
//     - Pointers wrap modulo FIFO_DEPTH.
//     - count is 0..FIFO_DEPTH.
//   Overflow and clear on the same edge: set wins.
//   busy_o = (FSM != IDLE) | !empty, registered-source, glitch-free.
// STRUCTURE
//   Package uart_pkg holds:
//     - register addresses: ADDR_TXDATA=0, ADDR_STATUS=1, ADDR_BAUDDIV=2
//     - STATUS bit positions
//     - FSM state encoding: IDLE/START/DATA/STOP, 2 bits
//   Sub-module uart_fifo: synchronous FIFO (clk_i, rst_ni, push, pop, din[7:0], dout[7:0], full, empty, count).
//     dout is first-word-fall-through.
//   Top level contains the bus decode, the FSM and the shifter.
// TESTING (BAUD_DIV=4, FIFO_DEPTH=4)
//   1. Write 0x55 to addr 0 at edge E:
//      tx_o low from E+1, then 1,0,1,0,1,0,1,0, then stop 1; each level lasts 4 cycles; 40 cycles total.
//   2. Write 0xA1,0xB2 back-to-back:
//      the second frame's start bit begins on the cycle after the first stop bit ends; busy_o=0 only after 80 cycles.
//   3. Write 6 bytes in 6 consecutive cycles:
//      bytes 1-5 are transmitted, byte 6 is dropped; STATUS reads overflow=1.
//      Writing 0x8 to addr 1 clears overflow; the STATUS bit 3 reading is then 0.
//   4. Write 0 to addr 2, then send 0xFF:
//      BAUDDIV reads 1; the frame lasts 10 cycles.
//      Write 8 mid-frame: the current frame is unchanged and the next frame lasts 80 cycles.
//   5. Assert rst_ni low during bit 3 of a frame with 2 bytes queued:
//      tx_o=1 and busy_o=0 immediately; STATUS=0x4 after release; no further frames.
//   6. Read addrs 0 and 5 and read with memread_i=0:
//      dato_o=0 in all cases; a write to addr 5 changes no state.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register addresses, STATUS bit positions and the serialiser state encoding.
package uart_pkg;

    localparam logic [5:0] ADDR_TXDATA  = 6'd0;
    localparam logic [5:0] ADDR_STATUS  = 6'd1;
    localparam logic [5:0] ADDR_BAUDDIV = 6'd2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_EMPTY   = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word-fall-through output; DEPTH must be a power of two.
// The caller guarantees no pop when empty and no push when full unless also popping.
module uart_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= din;
    end

    assign dout  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory bus:
// bus decode, TX FIFO, serialiser FSM and shifter.
module uart_tx_mmio #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [5:0]  addr_i,
    input  logic [31:0] dato_i,
    input  logic        memwrite_i,
    input  logic        memread_i,
    output logic [31:0] dato_o,
    output logic        tx_o,
    output logic        busy_o
);
    import uart_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_q, state_d;
    logic [15:0]   div_r, bdiv_r, baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_r;
    logic          overflow;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          bit_end;
    logic          wr_txdata, wr_status, wr_baud;
    logic [31:0]   status_w;
    logic          unused_dato;

    assign wr_txdata   = memwrite_i && (addr_i == ADDR_TXDATA);
    assign wr_status   = memwrite_i && (addr_i == ADDR_STATUS);
    assign wr_baud     = memwrite_i && (addr_i == ADDR_BAUDDIV);
    assign unused_dato = ^dato_i[31:16];

    // A full FIFO still accepts a byte on the edge where the serialiser pops.
    assign fifo_push = wr_txdata && (!fifo_full || fifo_pop);

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (dato_i[7:0]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_r    <= 16'(BAUD_DIV);
            overflow <= 1'b0;
        end else begin
            if (wr_baud) div_r <= (dato_i[15:0] == '0) ? 16'd1 : dato_i[15:0];
            if (wr_txdata && !fifo_push)         overflow <= 1'b1;
            else if (wr_status && dato_i[STAT_OVF]) overflow <= 1'b0;
        end
    end

    assign bit_end = (baud_cnt == bdiv_r - 16'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA:  if (bit_end && bit_cnt == 3'd7) state_d = ST_STOP;
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_r  <= '0;
            bdiv_r   <= 16'd1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (fifo_pop) begin
            shift_r  <= fifo_dout;
            bdiv_r   <= div_r;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_q != ST_IDLE) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (state_q == ST_DATA) begin
                    shift_r <= {1'b0, shift_r[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        case (state_q)
            ST_START: tx_o = 1'b0;
            ST_DATA:  tx_o = shift_r[0];
            default:  tx_o = 1'b1;
        endcase
        busy_o = (state_q != ST_IDLE) || !fifo_empty;
    end

    always_comb begin
        status_w                        = '0;
        status_w[STAT_BUSY]             = busy_o;
        status_w[STAT_FULL]             = fifo_full;
        status_w[STAT_EMPTY]            = fifo_empty;
        status_w[STAT_OVF]              = overflow;
        status_w[STAT_CNT_LSB +: 4]     = 4'(fifo_count);
    end

    always_comb begin
        dato_o = '0;
        if (memread_i) begin
            case (addr_i)
                ADDR_STATUS:  dato_o = status_w;
                ADDR_BAUDDIV: dato_o = {16'h0000, div_r};
                default:      dato_o = '0;
            endcase
        end
    end

endmodule
